// File: rtl/mips_mc_core.sv
// Multicycle MIPS-subset core with req/ready handshakes on both memory ports.
// One instruction is in flight at a time; each memory port has at most one
// outstanding access, and the two ports are never requested together.
module mips_mc_core #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int          RETIRE_W      = 32,
   parameter bit          HALT_ON_FAULT = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req,
   output logic [31:0]         imem_addr,
   input  logic                imem_ready,
   input  logic [31:0]         imem_data,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic [31:0]         dmem_addr,
   output logic [31:0]         dmem_wdata,
   input  logic                dmem_ready,
   input  logic [31:0]         dmem_rdata,
   output logic                halted,
   output logic [RETIRE_W-1:0] retired
);

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

   localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                          OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
   localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22,
                          F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;
   localparam logic [RETIRE_W-1:0] ONE = RETIRE_W'(1);

   state_t      state;
   logic [31:0] pc, ir, a, b, alu_out, mdr;
   logic [31:0] rf [32];
   logic        imem_req_q;

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, wb_dest;
   logic [31:0] simm, pc4, alu_res, mem_addr, wb_val;
   logic        legal, taken, misaligned;
   logic        unused_ok;

   assign op        = ir[31:26];
   assign rs        = ir[25:21];
   assign rt        = ir[20:16];
   assign rd        = ir[15:11];
   assign funct     = ir[5:0];
   assign simm      = {{16{ir[15]}}, ir[15:0]};
   assign pc4       = pc + 32'd4;
   assign mem_addr  = a + simm;
   assign misaligned = (mem_addr[1:0] != 2'b00);
   assign taken     = (op == OP_BEQ) ? (a == b) : (a != b);
   assign wb_dest   = (op == OP_R) ? rd : rt;
   assign wb_val    = (op == OP_LW) ? mdr : alu_out;
   assign unused_ok = &{1'b0, ir[10:6]};

   // Fetch request is suppressed combinationally so it is low for the whole reset pulse
   assign imem_req   = imem_req_q & ~rst;
   assign imem_addr  = pc;
   assign dmem_addr  = alu_out;
   assign dmem_wdata = b;

   // Opcode/funct legality check used in DECODE
   always_comb begin
      legal = 1'b0;
      case (op)
         OP_R:    legal = funct inside {F_ADD, F_ADDU, F_SUB, F_AND, F_OR, F_SLT};
         OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   // ALU for R-type and addi; everything wraps at 32 bits
   always_comb begin
      alu_res = a + simm;
      if (op == OP_R) begin
         case (funct)
            F_SUB:   alu_res = a - b;
            F_AND:   alu_res = a & b;
            F_OR:    alu_res = a | b;
            F_SLT:   alu_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: alu_res = a + b;
         endcase
      end
   end

   // Control FSM, datapath registers and register file
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         ir         <= '0;
         a          <= '0;
         b          <= '0;
         alu_out    <= '0;
         mdr        <= '0;
         imem_req_q <= 1'b1;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         halted     <= 1'b0;
         retired    <= '0;
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else begin
         case (state)
            FETCH: begin
               if (imem_ready) begin
                  ir         <= imem_data;
                  imem_req_q <= 1'b0;
                  state      <= DECODE;
               end
            end
            DECODE: begin
               a <= rf[rs];
               b <= rf[rt];
               if (legal) begin
                  state <= EXEC;
               end else if (HALT_ON_FAULT) begin
                  halted <= 1'b1;
                  state  <= HALT;
               end else begin
                  pc         <= pc4;
                  imem_req_q <= 1'b1;
                  state      <= FETCH;
               end
            end
            EXEC: begin
               if (op == OP_LW || op == OP_SW) begin
                  alu_out <= mem_addr;
                  if (!misaligned) begin
                     dmem_req <= 1'b1;
                     dmem_we  <= (op == OP_SW);
                     state    <= MEM;
                  end else if (HALT_ON_FAULT) begin
                     halted <= 1'b1;
                     state  <= HALT;
                  end else begin
                     pc         <= pc4;
                     imem_req_q <= 1'b1;
                     state      <= FETCH;
                  end
               end else if (op == OP_BEQ || op == OP_BNE) begin
                  pc         <= taken ? pc4 + {simm[29:0], 2'b00} : pc4;
                  retired    <= retired + ONE;
                  imem_req_q <= 1'b1;
                  state      <= FETCH;
               end else if (op == OP_J) begin
                  pc         <= {pc4[31:28], ir[25:0], 2'b00};
                  retired    <= retired + ONE;
                  imem_req_q <= 1'b1;
                  state      <= FETCH;
               end else begin
                  alu_out <= alu_res;
                  state   <= WB;
               end
            end
            MEM: begin
               if (dmem_ready) begin
                  dmem_req <= 1'b0;
                  if (dmem_we) begin
                     pc         <= pc4;
                     retired    <= retired + ONE;
                     imem_req_q <= 1'b1;
                     state      <= FETCH;
                  end else begin
                     mdr   <= dmem_rdata;
                     state <= WB;
                  end
               end
            end
            WB: begin
               if (wb_dest != 5'd0) rf[wb_dest] <= wb_val;
               pc         <= pc4;
               retired    <= retired + ONE;
               imem_req_q <= 1'b1;
               state      <= FETCH;
            end
            default: begin
               halted     <= 1'b1;
               imem_req_q <= 1'b0;
               dmem_req   <= 1'b0;
               state      <= HALT;
            end
         endcase
      end
   end

endmodule
